// File: rtl/mmm_arbiter.sv
// -----------------------------------------------------------------------------
// mmm_arbiter
//
// Two-requester round-robin arbiter in front of one shared Montgomery
// multiplier core. The owner drives the core operands while it holds the
// grant. Each operation has four phases:
//   IDLE -> CRST (core held in reset for RST_CYCLES cycles)
//        -> RUN  (core released for MMM_CYCLES cycles)
//        -> DONE (one cycle: result-register load strobe and done pulse)
//        -> IDLE
// Requests are sampled only in IDLE. There is no preemption and no abort. An
// owner may drop its request early and the operation still completes.
//
// Parameters
//   MMM_CYCLES  cycles one multiplication occupies the core (1..65535)
//   RST_CYCLES  cycles the core reset is held before each operation (1..15)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         global clock enable; 0 freezes every register
//   req[1:0]   request per requester, held high until its done pulse
//   gnt[1:0]   one-hot grant (or 00)
//   done[1:0]  one-cycle pulse to the owner when its result is valid
//   mmm_rst_n  active-low reset to the shared core
//   mmm_sel    operand/result mux select (index of the granted requester)
//   ld_r       one-cycle result-register load strobe
//   busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module mmm_arbiter #(
    parameter int MMM_CYCLES = 1028,
    parameter int RST_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic [1:0] done,
    output logic       mmm_rst_n,
    output logic       mmm_sel,
    output logic       ld_r,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CRST = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Terminal counts. The counter restarts at zero on every state change,
    // so it never needs to wrap.
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] RUN_LAST = 16'(MMM_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic        last_reg, last_next;

    logic [1:0]  gnt_reg, gnt_next;
    logic [1:0]  done_reg, done_next;
    logic        mmm_rst_n_reg, mmm_rst_n_next;
    logic        mmm_sel_reg, mmm_sel_next;
    logic        ld_r_reg, ld_r_next;

    logic        any_req;
    logic        winner;
    logic        take;

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
    assign any_req = |req;

    // A sole requester always wins. On a tie the requester that was not
    // served last wins. last resets to 1, so requester 0 wins the first tie.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_reg;
        end
    end

    // A new operation is accepted only in IDLE.
    assign take = (state_reg == IDLE) && any_req;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 16'd0;
            last_reg  <= 1'b1;
        end else if (en) begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            last_reg  <= last_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next = CRST;
                end
            end
            CRST: begin
                if (cnt_reg == RST_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (cnt_reg == RUN_LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The cycle counter only runs while CRST or RUN persists. It clears on
    // every transition and stays at zero in IDLE and DONE.
    always_comb begin
        cnt_next = 16'd0;
        if ((state_next == state_reg) &&
            ((state_reg == CRST) || (state_reg == RUN))) begin
            cnt_next = cnt_reg + 16'd1;
        end
    end

    always_comb begin
        last_next = last_reg;
        if (take) begin
            last_next = winner;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic
    // -------------------------------------------------------------------------
    // The outputs are registered and loaded with the values belonging to the
    // state being entered. They therefore change on the same edge as the state
    // and cannot glitch at the core or the requesters.
    always_comb begin
        mmm_sel_next = mmm_sel_reg;
        if (take) begin
            mmm_sel_next = winner;
        end
    end

    // The core is released for RUN and stays released through DONE, so the
    // result is still valid while it is loaded.
    always_comb begin
        mmm_rst_n_next = (state_next == RUN) || (state_next == DONE);
        ld_r_next      = (state_next == DONE);
    end

    // Per-requester grant and done decode. done is derived from the grant, so
    // it is always a subset of gnt.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_owner
            always_comb begin
                gnt_next[gi]  = (state_next != IDLE) && (mmm_sel_next == 1'(gi));
                done_next[gi] = (state_next == DONE) && gnt_next[gi];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_reg       <= 2'b00;
            done_reg      <= 2'b00;
            mmm_rst_n_reg <= 1'b0;
            mmm_sel_reg   <= 1'b0;
            ld_r_reg      <= 1'b0;
        end else if (en) begin
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            mmm_rst_n_reg <= mmm_rst_n_next;
            mmm_sel_reg   <= mmm_sel_next;
            ld_r_reg      <= ld_r_next;
        end
    end

    assign gnt       = gnt_reg;
    assign done      = done_reg;
    assign mmm_rst_n = mmm_rst_n_reg;
    assign mmm_sel   = mmm_sel_reg;
    assign ld_r      = ld_r_reg;

    // busy is decoded from the state register. It falls as soon as an
    // asynchronous reset forces IDLE.
    assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mmm_arbiter.sv
module tb_mmm_arbiter;

    localparam int MC  = 8;
    localparam int RC  = 2;
    localparam int LAT = RC + MC;   // grant edge to DONE edge

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] done;
    logic       mmm_rst_n;
    logic       mmm_sel;
    logic       ld_r;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int idx;
        int at;
    } exp_t;

    exp_t sb[$];

    mmm_arbiter #(
        .MMM_CYCLES(MC),
        .RST_CYCLES(RC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .done      (done),
        .mmm_rst_n (mmm_rst_n),
        .mmm_sel   (mmm_sel),
        .ld_r      (ld_r),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, expv, cyc);
        end
    endtask

    function automatic logic [1:0] oh(input int i);
        logic [1:0] one;
        one = 2'b01;
        return one << i;
    endfunction

    // Scoreboard: every done/ld_r observation must match the oldest
    // expectation in requester and cycle.
    always @(negedge clk) begin
        if (!rst) begin
            chk("done_in_gnt", 32'(done & ~gnt), 32'd0);
            chk("ldr_vs_done", 32'(ld_r), 32'(|done));
            if ((done != 2'b00) || ld_r) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'({done, ld_r}), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("done_vec", 32'(done), 32'(oh(e.idx)));
                    chk("done_cycle", 32'(cyc), 32'(e.at));
                    $display("op done: requester %0d at cycle %0d (expected %0d)", e.idx, cyc, e.at);
                end
            end
        end
    end

    task automatic push_exp(input int idx, input int at);
        exp_t e;
        e.idx = idx;
        e.at  = at;
        sb.push_back(e);
    endtask

    // Called at a negedge: raise req and check the grant one edge later.
    task automatic start_op(input logic [1:0] r, input int idx, input int extra, output int c);
        c   = cyc;
        req = r;
        push_exp(idx, c + 1 + LAT + extra);
        @(negedge clk);
        chk("grant", 32'(gnt), 32'(oh(idx)));
        chk("sel", 32'(mmm_sel), 32'(idx));
        chk("busy_on", 32'(busy), 32'd1);
        chk("rstn_crst", 32'(mmm_rst_n), 32'd0);
    endtask

    // Wait for the done cycle, drop req there, and check the release.
    task automatic finish_op(input int done_at);
        while (cyc < done_at) @(negedge clk);
        req = 2'b00;
        @(negedge clk);
        chk("release_gnt", 32'(gnt), 32'd0);
        chk("release_busy", 32'(busy), 32'd0);
        chk("release_rstn", 32'(mmm_rst_n), 32'd0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c;
        int p;
        int n;
        int t;
        logic [1:0] g_hold;
        logic       r_hold;

        rst = 1'b1;
        en  = 1'b1;
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rstn", 32'(mmm_rst_n), 32'd0);
        chk("rst_sel", 32'(mmm_sel), 32'd0);
        chk("rst_ldr", 32'(ld_r), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_gnt", 32'(gnt), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Single operation from requester 0 with full reset/run profile.
        start_op(2'b01, 0, 0, c);
        for (int k = 2; k <= LAT + 2; k++) begin
            @(negedge clk);
            chk($sformatf("prof_rstn_k%0d", k), 32'(mmm_rst_n),
                32'((k >= RC + 1) && (k <= LAT + 1)));
            chk($sformatf("prof_gnt_k%0d", k), 32'(gnt),
                (k <= LAT + 1) ? 32'(oh(0)) : 32'd0);
            if (k == LAT + 1) req = 2'b00;
        end

        // Continuous tie from reset: grants go 0,1,0 with one IDLE cycle between.
        do_reset();
        c   = cyc;
        req = 2'b11;
        for (int i = 0; i < 3; i++) push_exp(i % 2, c + 1 + LAT + i * (LAT + 2));
        for (int k = 1; k <= 3 * (LAT + 2); k++) begin
            @(negedge clk);
            p = (k - 1) % (LAT + 2);
            n = (k - 1) / (LAT + 2);
            chk($sformatf("rr_gnt_k%0d", k), 32'(gnt), (p <= LAT) ? 32'(oh(n % 2)) : 32'd0);
            chk($sformatf("rr_busy_k%0d", k), 32'(busy), 32'(p <= LAT));
            if (k == 3 * (LAT + 2) - 1) req = 2'b00;
        end

        // Request from 1 during RUN of 0 is not granted before the next IDLE.
        start_op(2'b01, 0, 0, c);
        while (cyc < c + 5) @(negedge clk);
        req = 2'b11;
        while (cyc < c + 1 + LAT) begin
            @(negedge clk);
            chk("nopreempt_gnt", 32'(gnt), 32'(oh(0)));
        end
        req = 2'b10;
        @(negedge clk);
        chk("gap_gnt", 32'(gnt), 32'd0);
        chk("gap_busy", 32'(busy), 32'd0);
        push_exp(1, cyc + 1 + LAT);
        t = cyc + 1 + LAT;
        @(negedge clk);
        chk("second_gnt", 32'(gnt), 32'(oh(1)));
        finish_op(t);

        // Clock enable low for 5 cycles mid-RUN.
        start_op(2'b01, 0, 5, c);
        while (cyc < c + 5) @(negedge clk);
        en     = 1'b0;
        g_hold = gnt;
        r_hold = mmm_rst_n;
        repeat (5) begin
            @(negedge clk);
            chk("frz_gnt", 32'(gnt), 32'(g_hold));
            chk("frz_rstn", 32'(mmm_rst_n), 32'(r_hold));
            chk("frz_busy", 32'(busy), 32'd1);
        end
        en = 1'b1;
        finish_op(c + 1 + LAT + 5);

        // Owner drops its request in RUN; the operation still completes.
        start_op(2'b01, 0, 0, c);
        while (cyc < c + 6) @(negedge clk);
        req = 2'b00;
        finish_op(c + 1 + LAT);

        // Asynchronous reset in RUN: immediate outputs, no done, then 0 wins a tie.
        start_op(2'b01, 0, 0, c);
        void'(sb.pop_back());   // this operation is aborted
        while (cyc < c + 9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 32'd0);
        chk("arst_rstn", 32'(mmm_rst_n), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        req = 2'b11;
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_gnt", 32'(gnt), 32'(oh(0)));
        push_exp(0, cyc + LAT);
        finish_op(cyc + LAT);

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
